// File: rtl/cla_pkg.sv
// Shared types and the golden reference adder for the carry-lookahead BIST checker.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CLA_W = 4;
  localparam int NVEC  = 2 ** (2 * CLA_W + 1);

  // Wide enough for any supported operand width; callers truncate to W+1 bits.
  localparam int GW = 32;

  function automatic logic [GW:0] golden_add(input logic [GW-1:0] a,
                                             input logic [GW-1:0] b,
                                             input logic          cin);
    return {1'b0, a} + {1'b0, b} + {{GW{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/cla_bist_checker_if.sv
// Stimulus/response bus between the BIST checker and the adder under test.
interface cla_bist_checker_if #(
  parameter int W = 4
);
  logic [W-1:0] dut_a;
  logic [W-1:0] dut_b;
  logic         dut_cin;
  logic [W-1:0] dut_sum;
  logic         dut_cout;

  modport master (output dut_a, dut_b, dut_cin, input dut_sum, dut_cout);
  modport slave  (input dut_a, dut_b, dut_cin, output dut_sum, dut_cout);
endinterface

// File: rtl/cla_exp_pipe.sv
// Valid+data delay line that keeps the expected result aligned with the adder latency.
module cla_exp_pipe #(
  parameter int DATA_W = 8,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] din,
  output logic              vld_out,
  output logic [DATA_W-1:0] dout
);
  logic [STAGES-1:0] vld_p;
  logic [DATA_W-1:0] data_p [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= vld_in;
      for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    data_p[0] <= din;
    for (int i = 1; i < STAGES; i++) data_p[i] <= data_p[i-1];
  end

  assign vld_out = vld_p[STAGES-1];
  assign dout    = data_p[STAGES-1];
endmodule

// File: rtl/cla_bist_checker.sv
// Exhaustive on-chip exerciser for a W-bit adder: issues every {a,b,cin}, checks
// each result against a golden sum and records error count and first failure.
module cla_bist_checker
  import cla_pkg::*;
#(
  parameter int W       = 4,
  parameter int DUT_LAT = 0,
  parameter int ERRW    = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  cla_bist_checker_if.master        dut,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ERRW-1:0]           err_count,
  output logic [2*W:0]              fail_vec,
  output logic [W:0]                fail_got
);
  localparam int VW = 2 * W + 1;
  localparam int RW = W + 1;
  localparam int PW = VW + RW;
  localparam logic [VW-1:0] LAST_VEC = '1;

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    return (&v) ? v : v + ERRW'(1);
  endfunction

  state_t          state, state_nxt;
  logic [VW-1:0]   vec;
  logic            issue;
  logic [VW-1:0]   issue_vec;
  logic [RW-1:0]   issue_exp;
  logic            start_run;

  logic [W-1:0]    a_p0, b_p0;
  logic            cin_p0;

  logic            chk_vld;
  logic [PW-1:0]   pipe_dout;
  logic [VW-1:0]   chk_vec;
  logic [RW-1:0]   chk_exp;
  logic [RW-1:0]   got;
  logic            mismatch;

  assign start_run = start && (state != RUN);

  assign issue_exp = RW'(golden_add(GW'(issue_vec[VW-1:W+1]),
                                    GW'(issue_vec[W:1]),
                                    issue_vec[0]));

  // Next vector is issued on every RUN edge until the all-ones vector is out;
  // DONE follows once the last expected value has drained out of the pipe.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    issue_vec = vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          issue     = 1'b1;
          issue_vec = '0;
        end
      end
      RUN: begin
        if (vec != LAST_VEC) begin
          issue     = 1'b1;
          issue_vec = vec + VW'(1);
        end else if (!chk_vld) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: registered stimulus, expected value enters the delay line ----
  cla_exp_pipe #(
    .DATA_W (PW),
    .STAGES (DUT_LAT + 1)
  ) u_exp_pipe (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (issue),
    .din     ({issue_vec, issue_exp}),
    .vld_out (chk_vld),
    .dout    (pipe_dout)
  );

  // ---- stage p(DUT_LAT+1): compare adder response with delayed expectation ----
  assign {chk_vec, chk_exp} = pipe_dout;
  assign got      = {dut.dut_cout, dut.dut_sum};
  assign mismatch = (state == RUN) && chk_vld && (got != chk_exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      cin_p0    <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
      fail_got  <= '0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        vec    <= issue_vec;
        a_p0   <= issue_vec[VW-1:W+1];
        b_p0   <= issue_vec[W:1];
        cin_p0 <= issue_vec[0];
      end
      if (start_run) begin
        err_count <= '0;
        fail_vec  <= '0;
        fail_got  <= '0;
      end else if (mismatch) begin
        err_count <= sat_inc(err_count);
        if (err_count == '0) begin
          fail_vec <= chk_vec;
          fail_got <= got;
        end
      end
    end
  end

  assign dut.dut_a   = a_p0;
  assign dut.dut_b   = b_p0;
  assign dut.dut_cin = cin_p0;

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);
endmodule

// File: tb/tb_cla_bist_checker.sv
// Scoreboard bench: three checker instances (latency 0, latency 2, narrow error counter)
// each driving a behavioural adder with selectable faults.
module tb_cla_bist_checker;
  import cla_pkg::*;

  typedef struct {
    int lat;
    int pass;
    int err;
    bit err_nz;
    bit chk_fv;
    int fv;
    int fg;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start0, start2, start4;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int mode0 = 0;  // 0 good, 1 sum[0] stuck-0, 2 cout stuck-0, 3 two-stage output wrapper

  exp_t q0[$], q2[$], q4[$];
  int   t0 = 0, t2 = 0, t4 = 0;

  cla_bist_checker_if #(.W(4)) if0 ();
  cla_bist_checker_if #(.W(4)) if2 ();
  cla_bist_checker_if #(.W(4)) if4 ();

  logic       busy0, done0, pass0, busy2, done2, pass2, busy4, done4, pass4;
  logic [9:0] err0, err2;
  logic [3:0] err4;
  logic [8:0] fv0, fv2, fv4;
  logic [4:0] fg0, fg2, fg4;

  cla_bist_checker #(.W(4), .DUT_LAT(0), .ERRW(10)) u0 (
    .clk(clk), .rst(rst), .start(start0), .dut(if0.master), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .fail_vec(fv0), .fail_got(fg0));
  cla_bist_checker #(.W(4), .DUT_LAT(2), .ERRW(10)) u2 (
    .clk(clk), .rst(rst), .start(start2), .dut(if2.master), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .fail_vec(fv2), .fail_got(fg2));
  cla_bist_checker #(.W(4), .DUT_LAT(0), .ERRW(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .dut(if4.master), .busy(busy4), .done(done4),
    .pass(pass4), .err_count(err4), .fail_vec(fv4), .fail_got(fg4));

  function automatic logic [4:0] add5(input logic [3:0] a, input logic [3:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {4'b0000, c};
  endfunction

  logic [4:0] r0_comb, r0_d1, r0_d2, r2_d1, r2_d2;
  always_comb begin
    r0_comb = add5(if0.dut_a, if0.dut_b, if0.dut_cin);
    if (mode0 == 1) r0_comb[0] = 1'b0;
    if (mode0 == 2) r0_comb[4] = 1'b0;
  end
  always @(posedge clk) begin
    r0_d1 <= r0_comb;
    r0_d2 <= r0_d1;
    r2_d1 <= add5(if2.dut_a, if2.dut_b, if2.dut_cin);
    r2_d2 <= r2_d1;
  end
  assign {if0.dut_cout, if0.dut_sum} = (mode0 == 3) ? r0_d2 : r0_comb;
  assign {if2.dut_cout, if2.dut_sum} = r2_d2;
  assign {if4.dut_cout, if4.dut_sum} = add5(if4.dut_a, if4.dut_b, if4.dut_cin) & 5'b11110;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_res(input string nm, input exp_t e, input int lat, input int p,
                         input int er, input int fv, input int fg, input int bsy);
    chk({nm, ".latency"}, lat, e.lat);
    chk({nm, ".pass"}, p, e.pass);
    if (e.err_nz) chk({nm, ".err_nonzero"}, int'(er != 0), 1);
    else          chk({nm, ".err_count"}, er, e.err);
    if (e.chk_fv) begin
      chk({nm, ".fail_vec"}, fv, e.fv);
      chk({nm, ".fail_got"}, fg, e.fg);
    end
    chk({nm, ".busy_at_done"}, bsy, 0);
  endtask

  // Monitors: pop the expected result whenever an instance raises done.
  logic d0q = 1'b0, d2q = 1'b0, d4q = 1'b0;
  always @(negedge clk) begin
    if (done0 && !d0q) begin
      if (q0.size() == 0) chk("u0.unexpected_done", 1, 0);
      else chk_res("u0", q0.pop_front(), cyc - t0, int'(pass0), int'(err0), int'(fv0),
                   int'(fg0), int'(busy0));
    end
    if (done2 && !d2q) begin
      if (q2.size() == 0) chk("u2.unexpected_done", 1, 0);
      else chk_res("u2", q2.pop_front(), cyc - t2, int'(pass2), int'(err2), int'(fv2),
                   int'(fg2), int'(busy2));
    end
    if (done4 && !d4q) begin
      if (q4.size() == 0) chk("u4.unexpected_done", 1, 0);
      else chk_res("u4", q4.pop_front(), cyc - t4, int'(pass4), int'(err4), int'(fv4),
                   int'(fg4), int'(busy4));
    end
    d0q = done0;
    d2q = done2;
    d4q = done4;
  end

  task automatic pulse(input bit s0, input bit s2, input bit s4, input bit track);
    @(negedge clk);
    start0 = s0;
    start2 = s2;
    start4 = s4;
    if (track) begin
      if (s0) t0 = cyc + 1;
      if (s2) t2 = cyc + 1;
      if (s4) t4 = cyc + 1;
    end
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n = 0;
    while ((q0.size() + q2.size() + q4.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ".results_pending"}, q0.size() + q2.size() + q4.size(), 0);
    q0.delete();
    q2.delete();
    q4.delete();
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; start4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.busy", int'(busy0), 0);
    chk("rst.done", int'(done0), 0);
    chk("rst.pass", int'(pass0), 0);
    chk("rst.err_count", int'(err0), 0);
    chk("rst.fail_vec", int'(fv0), 0);
    chk("rst.fail_got", int'(fg0), 0);
    chk("rst.dut_a", int'(if0.dut_a), 0);
    chk("rst.dut_b", int'(if0.dut_b), 0);
    chk("rst.dut_cin", int'(if0.dut_cin), 0);

    start0 = 1'b1;
    @(negedge clk);
    chk("rst_over_start.busy", int'(busy0), 0);
    start0 = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Run 1: clean adder on u0, latency-2 adder on u2, sum[0] fault on the 4-bit counter
    q0.push_back('{513, 1, 0, 1'b0, 1'b1, 0, 0});
    q2.push_back('{515, 1, 0, 1'b0, 1'b1, 0, 0});
    q4.push_back('{513, 0, 15, 1'b0, 1'b1, 1, 0});
    pulse(1, 1, 1, 1);
    chk("run1.busy", int'(busy0), 1);
    chk("run1.vec0_a", int'(if0.dut_a), 0);
    repeat (5) @(negedge clk);
    chk("run1.vec5_b", int'(if0.dut_b), 2);
    chk("run1.vec5_cin", int'(if0.dut_cin), 1);
    wait_drain(700, "run1");
    repeat (3) @(negedge clk);
    chk("hold.done", int'(done0), 1);
    chk("hold.dut_a", int'(if0.dut_a), 15);
    chk("hold.dut_b", int'(if0.dut_b), 15);
    chk("hold.dut_cin", int'(if0.dut_cin), 1);

    // Run 2: sum[0] stuck-at-0 on u0; rerun the saturating instance from DONE
    mode0 = 1;
    q0.push_back('{513, 0, 256, 1'b0, 1'b1, 1, 0});
    q4.push_back('{513, 0, 15, 1'b0, 1'b1, 1, 0});
    pulse(1, 0, 1, 1);
    chk("run2.u4_err_cleared", int'(err4), 0);
    chk("run2.u4_busy", int'(busy4), 1);
    wait_drain(700, "run2");

    // Run 3: cout stuck-at-0
    mode0 = 2;
    q0.push_back('{513, 0, 256, 1'b0, 1'b1, 9'b0000_1111_1, 0});
    pulse(1, 0, 0, 1);
    wait_drain(700, "run3");

    // Run 4: two-stage adder checked with a zero-latency expectation
    mode0 = 3;
    q0.push_back('{513, 0, 0, 1'b1, 1'b0, 0, 0});
    pulse(1, 0, 0, 1);
    wait_drain(700, "run4");

    // Run 5: a start pulse in the middle of a run is ignored
    mode0 = 0;
    q0.push_back('{513, 1, 0, 1'b0, 1'b1, 0, 0});
    pulse(1, 0, 0, 1);
    repeat (98) @(negedge clk);
    pulse(1, 0, 0, 0);
    wait_drain(700, "run5");

    // Run 6: faulty run aborted by reset partway through
    mode0 = 1;
    pulse(1, 0, 0, 1);
    repeat (198) @(negedge clk);
    chk("abort.errs_before_rst", int'(err0 != 0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", int'(busy0), 0);
    chk("abort.done", int'(done0), 0);
    chk("abort.err_count", int'(err0), 0);
    chk("abort.fail_vec", int'(fv0), 0);
    chk("abort.dut_a", int'(if0.dut_a), 0);
    chk("abort.dut_b", int'(if0.dut_b), 0);
    chk("abort.state_idle", int'(u0.state == IDLE), 1);

    // Run 7: clean full run after the abort
    mode0 = 0;
    q0.push_back('{513, 1, 0, 1'b0, 1'b1, 0, 0});
    pulse(1, 0, 0, 1);
    wait_drain(700, "run7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
